// File: rtl/systolic_array_nxn_if.sv
// Streaming bus of the N x N systolic multiply engine: job control, k-slice
// input stream and result-row output stream.
interface systolic_array_nxn_if #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int ACC_WIDTH = 24,
  parameter int KW        = 16
);
  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   busy;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*WIDTH-1:0]     a_vec;
  logic [N*WIDTH-1:0]     b_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*ACC_WIDTH-1:0] out_row;
  logic                   out_last;
  logic                   done;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  busy, in_ready, out_valid, out_row, out_last, done
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output busy, in_ready, out_valid, out_row, out_last, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// Output-stationary N x N systolic engine computing C = A x B (A: N x K, B: K x N)
// with internal operand skewing, a run FSM and valid/ready streaming on both sides.
module systolic_array_nxn #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int ACC_WIDTH = 24,
  parameter int KW        = 16
) (
  input logic                 clk,
  input logic                 rst,
  systolic_array_nxn_if.slave bus
);

  localparam int DW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_q;
  logic [DW-1:0] drain_q;
  logic [RW-1:0] row_q;
  logic          done_q;

  logic fire, out_fire, clr, acc_en;
  logic last_beat, last_drain, last_row;
  logic busy_c, in_ready_c, out_valid_c, out_last_c;

  assign clr        = (state_q == S_CLEAR);
  assign acc_en     = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign fire       = bus.in_valid && in_ready_c;
  assign out_fire   = out_valid_c && bus.out_ready;
  assign last_beat  = (beat_q == k_q - KW'(1));
  assign last_drain = (drain_q == DW'(2 * N - 3));
  assign last_row   = (row_q == RW'(N - 1));

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    busy_c      = (state_q != S_IDLE);
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLEAR;
      S_CLEAR: state_d = (k_q == '0) ? S_OUT : S_FEED;
      S_FEED: begin
        in_ready_c = 1'b1;
        if (fire && last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: if (last_drain) state_d = S_OUT;
      S_OUT: begin
        out_valid_c = 1'b1;
        out_last_c  = last_row;
        if (out_fire && last_row) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_fire && last_row;
      if (state_q == S_IDLE && bus.start) k_q <= bus.k_len;
      if (clr) begin
        beat_q  <= '0;
        drain_q <= '0;
        row_q   <= '0;
      end else begin
        if (fire)                beat_q  <= beat_q + KW'(1);
        if (state_q == S_DRAIN)  drain_q <= drain_q + DW'(1);
        if (out_fire)            row_q   <= row_q + RW'(1);
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.done      = done_q;

  // Edge operands: row i of A / column j of B enter the grid after i / j
  // register stages; a cycle without a handshake injects a zero bubble.
  logic [N*WIDTH-1:0] a_edge_flat, b_edge_flat;

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [WIDTH-1:0] a_new, b_new;
    assign a_new = fire ? bus.a_vec[i*WIDTH +: WIDTH] : '0;
    assign b_new = fire ? bus.b_vec[i*WIDTH +: WIDTH] : '0;

    if (i == 0) begin : g_direct
      assign a_edge_flat[WIDTH-1:0] = a_new;
      assign b_edge_flat[WIDTH-1:0] = b_new;
    end else begin : g_delay
      logic [WIDTH-1:0] a_sr [i];
      logic [WIDTH-1:0] b_sr [i];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_new;
          b_sr[0] <= b_new;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end

      assign a_edge_flat[i*WIDTH +: WIDTH] = a_sr[i-1];
      assign b_edge_flat[i*WIDTH +: WIDTH] = b_sr[i-1];
    end
  end

  logic signed [WIDTH-1:0]   a_at   [N][N];
  logic signed [WIDTH-1:0]   b_at   [N][N];
  logic signed [WIDTH-1:0]   a_pass [N][N-1];
  logic signed [WIDTH-1:0]   b_pass [N-1][N];
  logic signed [2*WIDTH-1:0] prod   [N][N];
  logic [ACC_WIDTH-1:0]      acc    [N][N];

  // Operand seen by PE(i,j): grid edge for column/row 0, else the neighbour's pass register.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_at[i][0] = signed'(a_edge_flat[i*WIDTH +: WIDTH]);
      for (int j = 1; j < N; j++) a_at[i][j] = a_pass[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      b_at[0][j] = signed'(b_edge_flat[j*WIDTH +: WIDTH]);
      for (int i = 1; i < N; i++) b_at[i][j] = b_pass[i-1][j];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod[i][j] = a_at[i][j] * b_at[i][j];
  end

  // NOTE: the accumulator and pass-register arrays are reset explicitly because
  // an abandoned job must not leak partial sums; plain storage arrays usually aren't.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0;
          if (j < N - 1) a_pass[i][j] <= '0;
          if (i < N - 1) b_pass[i][j] <= '0;
        end
    end else if (clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0;
          if (j < N - 1) a_pass[i][j] <= '0;
          if (i < N - 1) b_pass[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++)
          a_pass[i][j] <= a_at[i][j];
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++)
          b_pass[i][j] <= b_at[i][j];
      // Sums wrap modulo 2^ACC_WIDTH; the product is sign-extended by the cast.
      if (acc_en)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
    end
  end

  always_comb begin
    bus.out_row = '0;
    for (int j = 0; j < N; j++)
      bus.out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn: directed and randomized jobs checked
// against a plain matrix-product model, on a 24-bit and a 16-bit accumulator instance.
module tb_systolic_array_nxn;
  localparam int W     = 8;
  localparam int N     = 4;
  localparam int ACC   = 24;
  localparam int ACC16 = 16;
  localparam int KW    = 16;
  localparam int MAXK  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_array_nxn_if #(.WIDTH(W), .N(N), .ACC_WIDTH(ACC),   .KW(KW)) bus ();
  systolic_array_nxn_if #(.WIDTH(W), .N(N), .ACC_WIDTH(ACC16), .KW(KW)) bus16 ();

  assign bus16.start     = bus.start;
  assign bus16.k_len     = bus.k_len;
  assign bus16.in_valid  = bus.in_valid;
  assign bus16.a_vec     = bus.a_vec;
  assign bus16.b_vec     = bus.b_vec;
  assign bus16.out_ready = bus.out_ready;

  systolic_array_nxn #(.WIDTH(W), .N(N), .ACC_WIDTH(ACC), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  systolic_array_nxn #(.WIDTH(W), .N(N), .ACC_WIDTH(ACC16), .KW(KW)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     a_m [N][MAXK];
  int     b_m [MAXK][N];
  longint c_m [N][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_m[i][j] = 0;
        for (int kk = 0; kk < k; kk++)
          c_m[i][j] += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
      end
  endfunction

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int x = 0; x < N; x++) begin
        a_m[x][kk] = int'($urandom_range(0, 255)) - 128;
        b_m[kk][x] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_in_ready"},  bus.in_ready,  0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"},  bus.out_last,  0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_row24"},     bus.out_row,   0);
    check({tag, "_row16"},     bus16.out_row, 0);
  endtask

  // vmode: 0 = in_valid always 1, 1 = toggling 1,0,1.. over FEED cycles, 2 = random.
  // rmode: 0 = out_ready always 1, 1 = row 1 held off for 5 cycles, 2 = random.
  task automatic run_job(input int k, input int vmode, input int rmode, input bit noise);
    logic [63:0] m24, m16;
    int  beat, row, cyc, stall, ready_seen, first_cyc;
    bit  v, rdy, done_exp, finished;
    m24 = (64'd1 << ACC) - 64'd1;
    m16 = (64'd1 << ACC16) - 64'd1;
    beat = 0; row = 0; cyc = 0; stall = 0; ready_seen = 0; first_cyc = -1;
    done_exp = 1'b0; finished = 1'b0;
    model(k);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.k_len     = KW'(k);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      check("done", bus.done, done_exp);
      if (done_exp) begin
        check("busy_at_done", bus.busy, 0);
        finished = 1'b1;
      end else begin
        check("busy", bus.busy, 1);
        // input stream
        if (bus.in_ready) ready_seen++;
        case (vmode)
          0:       v = 1'b1;
          1:       v = bus.in_ready && (ready_seen % 2 == 1);
          default: v = 1'($urandom_range(0, 1));
        endcase
        bus.in_valid = v;
        for (int x = 0; x < N; x++) begin
          if (v && beat < k) begin
            bus.a_vec[x*W +: W] = W'(a_m[x][beat]);
            bus.b_vec[x*W +: W] = W'(b_m[beat][x]);
          end else begin
            bus.a_vec[x*W +: W] = W'($urandom);
            bus.b_vec[x*W +: W] = W'($urandom);
          end
        end
        if (bus.in_ready && v) beat++;
        // output stream
        if (bus.out_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          check("out_valid16", bus16.out_valid, 1);
          if (row >= N) begin
            check("extra_row", 1, 0);
            rdy = 1'b1;
          end else begin
            for (int j = 0; j < N; j++) begin
              check($sformatf("c24[%0d][%0d]", row, j), bus.out_row[j*ACC +: ACC],
                    64'(c_m[row][j]) & m24);
              check($sformatf("c16[%0d][%0d]", row, j), bus16.out_row[j*ACC16 +: ACC16],
                    64'(c_m[row][j]) & m16);
            end
            check("out_last", bus.out_last, (row == N - 1));
            case (rmode)
              0: rdy = 1'b1;
              1: begin
                rdy = !(row == 1 && stall < 5);
                if (!rdy) stall++;
              end
              default: rdy = 1'($urandom_range(0, 1));
            endcase
          end
          bus.out_ready = rdy;
          if (rdy) begin
            if (row == N - 1) done_exp = 1'b1;
            row++;
          end
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        // start pulses while busy must be ignored
        if (noise && (bus.in_ready || bus.out_valid) && $urandom_range(0, 2) == 0) begin
          bus.start = 1'b1;
          bus.k_len = KW'($urandom_range(0, 9));
        end
      end
    end

    if (!finished) check("timeout", 0, 1);
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("beats_accepted", beat, k);
    check("rows_accepted", row, N);
    if (vmode == 0) begin
      check("ready_cycles", ready_seen, k);
      check("first_valid_cycle", first_cyc, (k == 0) ? 2 : k + 2 * N);
    end
    if (rmode == 1) check("stall_cycles", stall, 5);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_after_job", bus.busy, 0);
  endtask

  task automatic reset_mid_job();
    int beat;
    bit hit;
    beat = 0;
    hit  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(6);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.a_vec    = $urandom;
      bus.b_vec    = $urandom;
      if (bus.in_ready) begin
        if (beat == 2) hit = 1'b1;
        else beat++;
      end
    end
    check("reached_beat2", hit, 1);
    #1 rst = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.a_vec     = '0;
    bus.b_vec     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // identity x counting matrix
    for (int kk = 0; kk < 4; kk++)
      for (int x = 0; x < N; x++) begin
        a_m[x][kk] = (x == kk) ? 1 : 0;
        b_m[kk][x] = 4 * kk + x + 1;
      end
    run_job(4, 0, 0, 1'b0);

    // empty inner dimension
    run_job(0, 0, 0, 1'b0);

    // constant operands with input bubbles
    for (int kk = 0; kk < 3; kk++)
      for (int x = 0; x < N; x++) begin
        a_m[x][kk] = 2;
        b_m[kk][x] = -3;
      end
    run_job(3, 1, 0, 1'b0);

    // most negative operands: wraps the 16-bit instance
    for (int kk = 0; kk < 3; kk++)
      for (int x = 0; x < N; x++) begin
        a_m[x][kk] = -128;
        b_m[kk][x] = -128;
      end
    run_job(3, 0, 0, 1'b0);

    // output back-pressure on row 1
    fill_random(4);
    run_job(4, 0, 1, 1'b0);

    // reset abandons a job, then ignored start pulses on a fresh job
    fill_random(6);
    reset_mid_job();
    fill_random(5);
    run_job(5, 2, 2, 1'b1);

    for (int t = 0; t < 8; t++) begin
      int k;
      k = int'($urandom_range(1, 12));
      fill_random(k);
      run_job(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
